// File: rtl/shift_window_pkg.sv
// Shared types and width helpers for the sliding-window sequencing controller.
package shift_window_pkg;

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_GATHER  = 2'd1,
    S_PRESENT = 2'd2
  } state_e;

  // Bits needed to hold a fill level in 0..depth.
  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to hold a stride count in 0..stride.
  function automatic int unsigned stride_w(input int unsigned stride);
    return $clog2(stride + 1);
  endfunction

endpackage

// File: rtl/shift_window_ctrl.sv
// Sliding-window controller: gates the shift enable of a shift_reg_en datapath,
// tracks fill level and stride, and presents each window with valid/ready.
module shift_window_ctrl
  import shift_window_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STRIDE    = 1,
  parameter int unsigned WIN_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       flush_i,
  output logic                       shift_en_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [fill_w(DEPTH)-1:0]   fill_cnt_o,
  output logic [WIN_CNT_W-1:0]       win_cnt_o
);

  localparam int unsigned FILL_W   = fill_w(DEPTH);
  localparam int unsigned STRIDE_W = stride_w(STRIDE);

  localparam logic [FILL_W-1:0]   FILL_FULL   = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0]   FILL_LAST   = FILL_W'(DEPTH - 1);
  localparam logic [STRIDE_W-1:0] STRIDE_LAST = STRIDE_W'(STRIDE - 1);

  state_e                 state_q, state_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [STRIDE_W-1:0]    stride_q, stride_d;
  logic [WIN_CNT_W-1:0]   win_q, win_d;
  logic                   out_valid_q, out_valid_d;
  logic                   accept;
  logic                   handshake;

  // State and counter registers; reset dominates flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      fill_q      <= '0;
      stride_q    <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: fill, stride gathering and window hand-off sequencing.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    stride_d = stride_q;
    win_d    = handshake ? win_q + WIN_CNT_W'(1) : win_q;

    if (flush_i) begin
      state_d  = S_FILL;
      fill_d   = '0;
      stride_d = '0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (accept) begin
            if (fill_q != FILL_FULL) begin
              fill_d = fill_q + FILL_W'(1);
            end
            if (fill_q == FILL_LAST) begin
              state_d = S_PRESENT;
            end
          end
        end
        S_GATHER: begin
          if (accept) begin
            if (stride_q == STRIDE_LAST) begin
              stride_d = '0;
              state_d  = S_PRESENT;
            end else begin
              stride_d = stride_q + STRIDE_W'(1);
            end
          end
        end
        S_PRESENT: begin
          // An accept here implies a handshake, since in_ready needs out_ready.
          if (handshake) begin
            if (accept && (STRIDE == 1)) begin
              state_d = S_PRESENT;
            end else if (accept) begin
              state_d  = S_GATHER;
              stride_d = STRIDE_W'(1);
            end else begin
              state_d  = S_GATHER;
              stride_d = '0;
            end
          end
        end
        default: begin
          state_d  = S_FILL;
          fill_d   = '0;
          stride_d = '0;
        end
      endcase
    end

    out_valid_d = (state_d == S_PRESENT);
  end

  // Outputs: same-cycle handshake terms plus registered status.
  always_comb begin
    in_ready_o  = !flush_i && (!out_valid_q || out_ready_i);
    accept      = in_valid_i && in_ready_o;
    handshake   = out_valid_q && out_ready_i;
    shift_en_o  = accept;
    out_valid_o = out_valid_q;
    fill_cnt_o  = fill_q;
    win_cnt_o   = win_q;
  end

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Scoreboard bench for shift_window_ctrl: three configurations share one stimulus
// stream, each paired with a bench-side shift register driven by shift_en_o.
module tb_shift_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, flush, out_ready;
  logic [7:0] din;

  logic        r0, r1, r2, s0, s1, s2, v0, v1, v2;
  logic [2:0]  f0, f1;
  logic [0:0]  f2;
  logic [15:0] w0, w1;
  logic [2:0]  w2;

  shift_window_ctrl #(.DEPTH(4), .STRIDE(1), .WIN_CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(r0), .flush_i(flush),
    .shift_en_o(s0), .out_valid_o(v0), .out_ready_i(out_ready), .fill_cnt_o(f0), .win_cnt_o(w0));
  shift_window_ctrl #(.DEPTH(4), .STRIDE(2), .WIN_CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(r1), .flush_i(flush),
    .shift_en_o(s1), .out_valid_o(v1), .out_ready_i(out_ready), .fill_cnt_o(f1), .win_cnt_o(w1));
  shift_window_ctrl #(.DEPTH(1), .STRIDE(3), .WIN_CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(r2), .flush_i(flush),
    .shift_en_o(s2), .out_valid_o(v2), .out_ready_i(out_ready), .fill_cnt_o(f2), .win_cnt_o(w2));

  logic        rdy[3], sen[3], ov[3];
  logic [2:0]  fc[3];
  logic [15:0] wc[3];
  always_comb begin
    rdy[0] = r0; rdy[1] = r1; rdy[2] = r2;
    sen[0] = s0; sen[1] = s1; sen[2] = s2;
    ov[0]  = v0; ov[1]  = v1; ov[2]  = v2;
    fc[0]  = f0; fc[1]  = f1; fc[2]  = {2'b00, f2};
    wc[0]  = w0; wc[1]  = w1; wc[2]  = {13'd0, w2};
  end

  // Bench-side datapath: entry 0 newest, no reset (stale data masked by fill).
  logic [7:0] dp[3][4];
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sen[k]) begin
        dp[k][0] <= din;
        for (int i = 1; i < 4; i++) dp[k][i] <= dp[k][i-1];
      end
    end
  end

  function automatic int dep(input int k);  return (k == 2) ? 1 : 4; endfunction
  function automatic int str(input int k);  return k + 1;            endfunction
  function automatic int wmod(input int k); return (k == 2) ? 8 : 65536; endfunction

  // Reference model: accepts counted since last flush/reset, window due when
  // count reaches DEPTH and every STRIDE accepts thereafter.
  int           n[3];
  bit           pend[3];
  int           wins[3];
  logic [7:0]   hist[3][$];
  logic [31:0]  expq[3][$];
  bit           known = 1'b0;
  int           total = 0;
  int           bad   = 0;

  function automatic logic [31:0] pack_hist(input int k);
    logic [31:0] p = '0;
    for (int i = 0; i < dep(k); i++) p[8*i +: 8] = hist[k][i];
    return p;
  endfunction

  function automatic logic [31:0] pack_dp(input int k);
    logic [31:0] p = '0;
    for (int i = 0; i < dep(k); i++) p[8*i +: 8] = dp[k][i];
    return p;
  endfunction

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cfg%0d t=%0t got=%0h expected=%0h", nm, k, $time, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cyc(input bit rs, input bit v, input bit f, input bit r, input logic [7:0] d);
    bit er[3], ea[3], eh[3];
    rst = rs; in_valid = v; flush = f; out_ready = r; din = d;
    for (int k = 0; k < 3; k++) begin
      er[k] = !f && (!pend[k] || r);
      ea[k] = v && er[k];
      eh[k] = pend[k] && r;
    end
    @(negedge clk);
    if (known) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready", k, longint'(rdy[k]), longint'(er[k]));
        chk("shift_en", k, longint'(sen[k]), longint'(ea[k]));
        chk("out_valid", k, longint'(ov[k]), longint'(pend[k]));
        chk("fill_cnt", k, longint'(fc[k]), longint'((n[k] < dep(k)) ? n[k] : dep(k)));
        chk("win_cnt", k, longint'(wc[k]), longint'(wins[k] % wmod(k)));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rs) begin
        n[k] = 0; pend[k] = 1'b0; wins[k] = 0;
        hist[k].delete(); expq[k].delete();
      end else begin
        if (eh[k]) begin
          wins[k]++;
          pend[k] = 1'b0;
        end
        if (ea[k]) begin
          hist[k].push_front(d);
          if (hist[k].size() > dep(k)) void'(hist[k].pop_back());
          n[k]++;
          if (n[k] >= dep(k) && ((n[k] - dep(k)) % str(k)) == 0) begin
            pend[k] = 1'b1;
            expq[k].push_back(pack_hist(k));
          end
        end
        if (f) begin
          n[k] = 0; pend[k] = 1'b0;
          expq[k].delete();
        end
      end
    end
    if (rs) known = 1'b1;
    #1;
  endtask

  // Monitor: every DUT hand-off must match the next expected window.
  initial begin
    forever begin
      @(negedge clk);
      if (known && !rst && out_ready) begin
        for (int k = 0; k < 3; k++) begin
          if (ov[k]) begin
            if (expq[k].size() == 0) begin
              total++; bad++;
              $display("FAIL window cfg%0d t=%0t got=%0h expected=none", k, $time, pack_dp(k));
            end else begin
              chk("window", k, longint'(pack_dp(k)), longint'(expq[k].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; din = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);

    // Fill then back-to-back windows with ready high.
    for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 1, 8'(i));
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);

    // Backpressure: window held while ready low, then hand-off with accept.
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, 8'(i));
    for (int i = 0; i < 5; i++)  cyc(0, 1, 0, 0, 8'd5);
    cyc(0, 1, 0, 1, 8'd5);
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);

    // Stride run 1..8.
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 0, 1, 8'(i));
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);

    // Flush after two accepts, refill, then flush colliding with a sample.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 8'd1); cyc(0, 1, 0, 1, 8'd2);
    cyc(0, 0, 1, 1, 0);
    for (int i = 10; i <= 13; i++) cyc(0, 1, 0, 1, 8'(i));
    cyc(0, 1, 1, 1, 8'd7);
    cyc(0, 0, 0, 1, 0);

    // Reset while a window is held under backpressure.
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, 8'(20 + i));
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 1, 8'(30 + i));
    cyc(0, 0, 0, 1, 0);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom % 400) == 0,
          ($urandom % 4) != 0,
          ($urandom % 29) == 0,
          ($urandom % 3) != 0,
          8'($urandom));
    end
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
